fifo_rr_drain_arbiter: RTL and testbench

//  Shares one downstream channel among NUM_IN first-word fall-through FIFO outputs.

---
 rtl/fifo_rr_drain_arbiter_if.sv | 28 ++
 rtl/fifo_rr_drain_arbiter.sv | 151 +++++++++++++++
 tb/tb_fifo_rr_drain_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fifo_rr_drain_arbiter_if.sv
// Handshake bundle between NUM_IN FWFT FIFO outputs, the drain arbiter and the shared downstream port.
interface fifo_rr_drain_arbiter_if #(
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned DATA_WIDTH = 64
);
    localparam int unsigned ID_WIDTH = $clog2(NUM_IN);

    logic [NUM_IN-1:0]            i__in_valid;
    logic [NUM_IN*DATA_WIDTH-1:0] i__in_data;
    logic [NUM_IN-1:0]            o__in_ready;
    logic                         o__out_valid;
    logic [DATA_WIDTH-1:0]        o__out_data;
    logic [ID_WIDTH-1:0]          o__out_id;
    logic                         i__out_ready;
    logic                         o__busy;

    // Arbiter side.
    modport slave (
        input  i__in_valid, i__in_data, i__out_ready,
        output o__in_ready, o__out_valid, o__out_data, o__out_id, o__busy
    );

    // Environment side: FIFOs plus downstream consumer.
    modport master (
        output i__in_valid, i__in_data, i__out_ready,
        input  o__in_ready, o__out_valid, o__out_data, o__out_id, o__busy
    );
endinterface

// File: rtl/fifo_rr_drain_arbiter.sv
// Round-robin drain of NUM_IN FWFT FIFOs into one registered output slot,
// letting the granted FIFO send up to QUANTUM back-to-back beats per grant.
module fifo_rr_drain_arbiter #(
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned QUANTUM    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    fifo_rr_drain_arbiter_if.slave bus
);
    localparam int unsigned ID_WIDTH  = $clog2(NUM_IN);
    localparam int unsigned CNT_WIDTH = $clog2(QUANTUM + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]   owner_q, owner_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ID_WIDTH-1:0]   out_id_q, out_id_d;

    logic                  slot_free;
    logic                  win_found;
    logic [ID_WIDTH-1:0]   win_idx;
    logic [ID_WIDTH-1:0]   cand;
    logic                  accept;
    logic [ID_WIDTH-1:0]   acc_id;
    logic [CNT_WIDTH-1:0]  count_inc;
    logic [NUM_IN-1:0]     in_ready_c;
    logic [DATA_WIDTH-1:0] in_beats [NUM_IN];

    function automatic logic [ID_WIDTH-1:0] next_idx(input logic [ID_WIDTH-1:0] idx);
        if (idx == ID_WIDTH'(NUM_IN - 1)) begin
            return '0;
        end
        return idx + ID_WIDTH'(1);
    endfunction

    for (genvar k = 0; k < NUM_IN; k++) begin : g_unpack
        assign in_beats[k] = bus.i__in_data[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign slot_free = !out_valid_q || bus.i__out_ready;
    assign count_inc = count_q + CNT_WIDTH'(1);

    // First valid requester scanning upward from ptr with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = ptr_q;
        for (int i = 0; i < int'(NUM_IN); i++) begin
            if (!win_found && bus.i__in_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
            cand = next_idx(cand);
        end
    end

    // Next-state, pop strobes and output slot update.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        count_d     = count_q;
        in_ready_c  = '0;
        accept      = 1'b0;
        acc_id      = owner_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;

        unique case (state_q)
            IDLE: begin
                if (slot_free && win_found) begin
                    in_ready_c[win_idx] = 1'b1;
                    accept              = 1'b1;
                    acc_id              = win_idx;
                    owner_d             = win_idx;
                    count_d             = CNT_WIDTH'(1);
                    if (QUANTUM == 1) begin
                        ptr_d = next_idx(win_idx);
                    end else begin
                        state_d = GRANT;
                    end
                end
            end
            GRANT: begin
                if (slot_free) begin
                    if (bus.i__in_valid[owner_q]) begin
                        in_ready_c[owner_q] = 1'b1;
                        accept              = 1'b1;
                        count_d             = count_inc;
                    end
                    // Release on quantum exhausted or owner FIFO ran dry.
                    if (!bus.i__in_valid[owner_q] || count_inc == CNT_WIDTH'(QUANTUM)) begin
                        ptr_d   = next_idx(owner_q);
                        count_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_beats[acc_id];
            out_id_d    = acc_id;
        end else if (bus.i__out_ready) begin
            out_valid_d = 1'b0;
        end

        // No pop may escape while reset discards the grant.
        if (reset) begin
            in_ready_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    assign bus.o__in_ready  = in_ready_c;
    assign bus.o__out_valid = out_valid_q;
    assign bus.o__out_data  = out_data_q;
    assign bus.o__out_id    = out_id_q;
    assign bus.o__busy      = (state_q == GRANT) || out_valid_q;
endmodule

// File: tb/tb_fifo_rr_drain_arbiter.sv
// Bench for fifo_rr_drain_arbiter: per-cycle vector table plus scripted corner cases,
// with a scoreboard of accepted beats checked against the output slot.
module tb_fifo_rr_drain_arbiter;
    localparam int unsigned NUM_IN     = 4;
    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned QUANTUM    = 4;

    typedef struct {
        logic [3:0] v;
        logic       rdy;
        logic [3:0] e_rdy;
        logic       e_ov;
        logic [1:0] e_id;
        logic       e_busy;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  id;
    } beat_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fifo_rr_drain_arbiter_if #(.NUM_IN(NUM_IN), .DATA_WIDTH(DATA_WIDTH)) bus ();

    fifo_rr_drain_arbiter #(
        .NUM_IN(NUM_IN),
        .DATA_WIDTH(DATA_WIDTH),
        .QUANTUM(QUANTUM)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned tag   = 0;
    beat_t       sb[$];
    vec_t        tbl[$];

    function automatic logic [63:0] mk_data(input int unsigned k, input int unsigned t);
        return {8'(k), 24'hC0FFEE, 32'(t)};
    endfunction

    function automatic vec_t mkv(input logic [3:0] v, input logic rdy, input logic [3:0] e_rdy,
                                 input logic e_ov, input logic [1:0] e_id, input logic e_busy);
        vec_t r;
        r.v = v; r.rdy = rdy; r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_id = e_id; r.e_busy = e_busy;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: drive, check pop strobes and slot vs scoreboard, then registered outputs.
    task automatic step(input vec_t t, input string nm);
        beat_t b;
        @(negedge clk);
        reset            = 1'b0;
        bus.i__in_valid  = t.v;
        bus.i__out_ready = t.rdy;
        for (int k = 0; k < 4; k++) bus.i__in_data[k*64 +: 64] = mk_data(k, tag);
        #1;
        chk({nm, ".in_ready"}, 64'(bus.o__in_ready), 64'(t.e_rdy));
        if (bus.o__out_valid) begin
            chk({nm, ".sb_has_beat"}, 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                chk({nm, ".slot_data"}, bus.o__out_data, sb[0].data);
                chk({nm, ".slot_id"}, 64'(bus.o__out_id), 64'(sb[0].id));
                if (t.rdy) void'(sb.pop_front());
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (bus.i__in_valid[k] && bus.o__in_ready[k]) begin
                b.data = bus.i__in_data[k*64 +: 64];
                b.id   = 2'(k);
                sb.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        chk({nm, ".out_valid"}, 64'(bus.o__out_valid), 64'(t.e_ov));
        if (t.e_ov) chk({nm, ".out_id"}, 64'(bus.o__out_id), 64'(t.e_id));
        chk({nm, ".busy"}, 64'(bus.o__busy), 64'(t.e_busy));
        tag++;
    endtask

    task automatic do_reset(input logic [3:0] v, input string nm);
        @(negedge clk);
        reset            = 1'b1;
        bus.i__in_valid  = v;
        bus.i__out_ready = 1'b0;
        #1;
        chk({nm, ".in_ready_in_reset"}, 64'(bus.o__in_ready), 64'(0));
        @(posedge clk);
        #1;
        chk({nm, ".out_valid"}, 64'(bus.o__out_valid), 64'(0));
        chk({nm, ".busy"}, 64'(bus.o__busy), 64'(0));
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset            = 1'b1;
        bus.i__in_valid  = '0;
        bus.i__in_data   = '0;
        bus.i__out_ready = 1'b0;
        repeat (2) @(posedge clk);
        do_reset(4'b0000, "t1_reset");

        // Idle after reset.
        repeat (3) tbl.push_back(mkv(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0));
        // Quantum rotation 0,0,0,0,1,1,1,1,...,3,3,3,3,0 with no bubbles.
        for (int j = 0; j < 17; j++)
            tbl.push_back(mkv(4'b1111, 1'b1, 4'(1 << ((j / 4) % 4)), 1'b1, 2'((j / 4) % 4), 1'b1));
        tbl.push_back(mkv(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0));
        // Walk ptr to 3 via a grant to 2.
        tbl.push_back(mkv(4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1));
        tbl.push_back(mkv(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0));
        // ptr=3, only FIFO1 valid: wrap and skip to 1, then ptr=2.
        tbl.push_back(mkv(4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1));
        tbl.push_back(mkv(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0));
        tbl.push_back(mkv(4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1));
        tbl.push_back(mkv(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0));

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // Owner empties early: A,B from FIFO2, gap, C from FIFO3, ptr back to 0.
        do_reset(4'b0000, "t3_reset");
        step(mkv(4'b1100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1), "t3_a");
        step(mkv(4'b1100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1), "t3_b");
        step(mkv(4'b1000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0), "t3_gap");
        step(mkv(4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1), "t3_c");
        step(mkv(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0), "t3_rel");
        step(mkv(4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1), "t3_ptr0");
        step(mkv(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0), "t3_end");

        // Backpressure: slot held 5 cycles, count frozen at 1, then 3 more beats from 2.
        step(mkv(4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1), "t4_first");
        repeat (5) step(mkv(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1), "t4_stall");
        repeat (3) step(mkv(4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1), "t4_resume");
        step(mkv(4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1), "t4_rotate");

        // Reset mid-grant at count=2 with the slot full.
        step(mkv(4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1), "t6_count2");
        do_reset(4'b1111, "t6_reset");
        step(mkv(4'b1010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1), "t6_lowest");
        step(mkv(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0), "t6_drain");

        chk("sb_empty_at_end", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
